// File: rtl/patgen_core_if.sv
// Signal bundle between the sync generator, the pattern stage and its consumer.
// Signal names match the original port list so existing connections map one-to-one.
interface patgen_core_if #(
  parameter int COLOR_W = 8
);
  logic [1:0]         RESOL;
  logic [1:0]         PATSEL;
  logic               DSP_HSYNC_X;
  logic               DSP_VSYNC_X;
  logic               DSP_preDE;
  logic               PAT_HSYNC_X;
  logic               PAT_VSYNC_X;
  logic               PAT_DE;
  logic [COLOR_W-1:0] PAT_R;
  logic [COLOR_W-1:0] PAT_G;
  logic [COLOR_W-1:0] PAT_B;
  logic [7:0]         FRMCNT;

  modport master (
    output RESOL, PATSEL, DSP_HSYNC_X, DSP_VSYNC_X, DSP_preDE,
    input  PAT_HSYNC_X, PAT_VSYNC_X, PAT_DE, PAT_R, PAT_G, PAT_B, FRMCNT
  );

  modport slave (
    input  RESOL, PATSEL, DSP_HSYNC_X, DSP_VSYNC_X, DSP_preDE,
    output PAT_HSYNC_X, PAT_VSYNC_X, PAT_DE, PAT_R, PAT_G, PAT_B, FRMCNT
  );
endinterface

// File: rtl/patgen_core.sv
// Test-pattern stage: tracks active-pixel X/Y from syncgen timing and emits
// bars/grid/gradient/bouncing-box RGB with DE/syncs, all one DCLK after input.
module patgen_core #(
  parameter int BOX_SIZE = 64,
  parameter int COLOR_W  = 8
) (
  input  logic          DCLK,
  input  logic          DRST,
  patgen_core_if.slave  pif
);

  localparam logic [1:0]  PAT_BARS = 2'd0;
  localparam logic [1:0]  PAT_GRID = 2'd1;
  localparam logic [1:0]  PAT_GRAD = 2'd2;
  localparam logic [1:0]  PAT_BOX  = 2'd3;
  localparam logic [10:0] PX_MAX   = 11'd2047;
  localparam logic [10:0] BOX      = 11'(BOX_SIZE);

  logic        vs_d, de_d;
  logic [10:0] px, py;
  logic [1:0]  mode;
  logic [10:0] hsize, vsize;
  logic [7:0]  barw;
  logic [10:0] bx, by;
  logic        dirx, diry;   // 0 = right/down, 1 = left/up
  logic [7:0]  frmcnt;

  logic        frame_start, de_fall;
  logic [10:0] new_hsize, new_vsize;
  logic [7:0]  new_barw;
  logic [2:0]  bar_idx;
  logic        grid_on, box_on;
  logic [COLOR_W-1:0] r_n, g_n, b_n;

  assign frame_start = vs_d & ~pif.DSP_VSYNC_X;
  assign de_fall     = de_d & ~pif.DSP_preDE;

  always_comb begin
    new_hsize = 11'd640;
    new_vsize = 11'd480;
    new_barw  = 8'd80;
    case (pif.RESOL)
      2'd1:    begin new_hsize = 11'd800;  new_vsize = 11'd600;  new_barw = 8'd100; end
      2'd2:    begin new_hsize = 11'd1024; new_vsize = 11'd768;  new_barw = 8'd128; end
      2'd3:    begin new_hsize = 11'd1280; new_vsize = 11'd1024; new_barw = 8'd160; end
      default: begin new_hsize = 11'd640;  new_vsize = 11'd480;  new_barw = 8'd80;  end
    endcase
  end

  // Returns {dir, pos}; a position beyond the new limit (resolution shrank) is clamped first.
  function automatic logic [11:0] axis_step(input logic [10:0] pos, input logic dir,
                                            input logic [10:0] size);
    logic [10:0] lim;
    lim = size - BOX;
    if (pos > lim)
      axis_step = {1'b1, lim};
    else if (!dir && pos == lim)
      axis_step = {1'b1, pos - 11'd1};
    else if (dir && pos == 11'd0)
      axis_step = {1'b0, pos + 11'd1};
    else if (dir)
      axis_step = {1'b1, pos - 11'd1};
    else
      axis_step = {1'b0, pos + 11'd1};
  endfunction

  always_comb begin
    bar_idx = 3'd0;
    for (int unsigned k = 1; k <= 7; k++) begin
      if ({1'b0, px} >= 12'(k * barw))
        bar_idx = bar_idx + 3'd1;
    end
    grid_on = (px[5:0] == 6'd0) || (py[5:0] == 6'd0) ||
              (px == hsize - 11'd1) || (py == vsize - 11'd1);
    box_on  = (px >= bx) && ({1'b0, px} < {1'b0, bx} + 12'(BOX_SIZE)) &&
              (py >= by) && ({1'b0, py} < {1'b0, by} + 12'(BOX_SIZE));
    r_n = '0;
    g_n = '0;
    b_n = '0;
    case (mode)
      PAT_BARS: begin
        // white,yellow,cyan,green,magenta,red,blue,black reduces to inverted index bits
        r_n = {COLOR_W{~bar_idx[1]}};
        g_n = {COLOR_W{~bar_idx[2]}};
        b_n = {COLOR_W{~bar_idx[0]}};
      end
      PAT_GRID: begin
        r_n = {COLOR_W{grid_on}};
        g_n = {COLOR_W{grid_on}};
        b_n = {COLOR_W{grid_on}};
      end
      PAT_GRAD: begin
        r_n = COLOR_W'(px[7:0]);
        g_n = COLOR_W'(py[7:0]);
        b_n = COLOR_W'(px[7:0] ^ py[7:0]);
      end
      PAT_BOX: begin
        r_n = {COLOR_W{box_on}};
        g_n = {COLOR_W{box_on}};
        b_n = '1;
      end
      default: begin
        r_n = '0;
        g_n = '0;
        b_n = '0;
      end
    endcase
  end

  always_ff @(posedge DCLK) begin
    if (DRST) begin
      pif.PAT_HSYNC_X <= 1'b1;
      pif.PAT_VSYNC_X <= 1'b1;
      pif.PAT_DE      <= 1'b0;
      pif.PAT_R       <= '0;
      pif.PAT_G       <= '0;
      pif.PAT_B       <= '0;
      vs_d   <= 1'b1;
      de_d   <= 1'b0;
      px     <= '0;
      py     <= '0;
      mode   <= PAT_BARS;
      hsize  <= 11'd640;
      vsize  <= 11'd480;
      barw   <= 8'd80;
      bx     <= '0;
      by     <= '0;
      dirx   <= 1'b0;
      diry   <= 1'b0;
      frmcnt <= '0;
    end else begin
      pif.PAT_HSYNC_X <= pif.DSP_HSYNC_X;
      pif.PAT_VSYNC_X <= pif.DSP_VSYNC_X;
      pif.PAT_DE      <= pif.DSP_preDE;
      pif.PAT_R       <= pif.DSP_preDE ? r_n : '0;
      pif.PAT_G       <= pif.DSP_preDE ? g_n : '0;
      pif.PAT_B       <= pif.DSP_preDE ? b_n : '0;
      vs_d <= pif.DSP_VSYNC_X;
      de_d <= pif.DSP_preDE;

      if (pif.DSP_preDE)
        px <= (px == PX_MAX) ? px : px + 11'd1;
      else
        px <= '0;

      if (frame_start) begin
        py     <= '0;
        mode   <= pif.PATSEL;
        hsize  <= new_hsize;
        vsize  <= new_vsize;
        barw   <= new_barw;
        frmcnt <= frmcnt + 8'd1;
        {dirx, bx} <= axis_step(bx, dirx, new_hsize);
        {diry, by} <= axis_step(by, diry, new_vsize);
      end else if (de_fall && py != PX_MAX) begin
        py <= py + 11'd1;
      end
    end
  end

  assign pif.FRMCNT = frmcnt;

endmodule

// File: tb/tb_patgen_core.sv
// Directed bench for patgen_core: reset, alignment, bars, mode latch, grid,
// gradient saturation, box colouring, bounce/wrap and resolution clamp.
module tb_patgen_core;

  logic DCLK = 1'b0;
  logic DRST = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   de_cnt;
  logic [23:0] cap   [0:2199];
  logic        capde [0:2199];

  patgen_core_if #(.COLOR_W(8)) pif ();

  patgen_core #(.BOX_SIZE(64), .COLOR_W(8)) dut (
    .DCLK (DCLK),
    .DRST (DRST),
    .pif  (pif)
  );

  always #5 DCLK = ~DCLK;

  task automatic tick();
    @(posedge DCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_line(input int n);
    de_cnt = 0;
    for (int i = 0; i < n; i++) begin
      pif.DSP_preDE = 1'b1;
      tick();
      cap[i]   = {pif.PAT_R, pif.PAT_G, pif.PAT_B};
      capde[i] = pif.PAT_DE;
      if (pif.PAT_DE) de_cnt++;
    end
    pif.DSP_preDE = 1'b0;
    tick();
  endtask

  task automatic frame();
    pif.DSP_VSYNC_X = 1'b0;
    tick();
    pif.DSP_VSYNC_X = 1'b1;
    tick();
  endtask

  initial begin
    pif.RESOL = 2'd0;
    pif.PATSEL = 2'd0;
    pif.DSP_HSYNC_X = 1'b1;
    pif.DSP_VSYNC_X = 1'b1;
    pif.DSP_preDE = 1'b0;

    // reset
    tick();
    tick();
    chk("rst_hs", 32'(pif.PAT_HSYNC_X), 32'd1);
    chk("rst_vs", 32'(pif.PAT_VSYNC_X), 32'd1);
    chk("rst_de", 32'(pif.PAT_DE), 32'd0);
    chk("rst_rgb", 32'({pif.PAT_R, pif.PAT_G, pif.PAT_B}), 32'h0);
    chk("rst_frm", 32'(pif.FRMCNT), 32'd0);
    DRST = 1'b0;

    // sync alignment
    pif.DSP_HSYNC_X = 1'b0;
    tick();
    chk("hs_low", 32'(pif.PAT_HSYNC_X), 32'd0);
    chk("de_idle", 32'(pif.PAT_DE), 32'd0);
    pif.DSP_HSYNC_X = 1'b1;
    tick();
    chk("hs_high", 32'(pif.PAT_HSYNC_X), 32'd1);

    // 640-pixel line, bars at 640x480 from reset
    run_line(640);
    chk("de_first", 32'(capde[0]), 32'd1);
    chk("de_count", 32'(de_cnt), 32'd640);
    chk("de_after", 32'(pif.PAT_DE), 32'd0);
    chk("rgb_after", 32'({pif.PAT_R, pif.PAT_G, pif.PAT_B}), 32'h0);
    chk("bar_79", 32'(cap[79]), 32'hFFFFFF);
    chk("bar_80", 32'(cap[80]), 32'hFFFF00);
    chk("bar_160", 32'(cap[160]), 32'h00FFFF);
    chk("bar_560", 32'(cap[560]), 32'h000000);

    // frame start at 1280x1024
    pif.RESOL = 2'd3;
    pif.DSP_VSYNC_X = 1'b0;
    tick();
    chk("vs_low", 32'(pif.PAT_VSYNC_X), 32'd0);
    chk("frm_1", 32'(pif.FRMCNT), 32'd1);
    pif.DSP_VSYNC_X = 1'b1;
    tick();
    chk("vs_high", 32'(pif.PAT_VSYNC_X), 32'd1);
    run_line(200);
    chk("bar3_159", 32'(cap[159]), 32'hFFFFFF);
    chk("bar3_160", 32'(cap[160]), 32'hFFFF00);

    // mid-frame mode change is held off until next frame
    pif.PATSEL = 2'd2;
    pif.RESOL = 2'd0;
    run_line(16);
    chk("latch_bars", 32'(cap[5]), 32'hFFFFFF);
    frame();
    run_line(8);
    run_line(8);
    run_line(8);
    run_line(8);
    chk("grad_5_3", 32'(cap[5]), 32'h050306);

    // px saturation
    run_line(2100);
    chk("grad_2046", 32'(cap[2046][23:16]), 32'hFE);
    chk("grad_sat", 32'(cap[2050][23:16]), 32'hFF);

    // grid
    pif.PATSEL = 2'd1;
    frame();
    run_line(100);
    chk("grid_row0", 32'(cap[10]), 32'hFFFFFF);
    run_line(700);
    chk("grid_1_1", 32'(cap[1]), 32'h000000);
    chk("grid_64", 32'(cap[64]), 32'hFFFFFF);
    chk("grid_638", 32'(cap[638]), 32'h000000);
    chk("grid_639", 32'(cap[639]), 32'hFFFFFF);

    // reset in the middle of a line
    pif.DSP_preDE = 1'b1;
    DRST = 1'b1;
    tick();
    chk("mrst_de", 32'(pif.PAT_DE), 32'd0);
    chk("mrst_rgb", 32'({pif.PAT_R, pif.PAT_G, pif.PAT_B}), 32'h0);
    chk("mrst_frm", 32'(pif.FRMCNT), 32'd0);
    chk("mrst_bx", 32'(dut.bx), 32'd0);
    DRST = 1'b0;
    pif.DSP_preDE = 1'b0;
    tick();

    // box: after one frame bx=by=1
    pif.PATSEL = 2'd3;
    pif.RESOL = 2'd0;
    frame();
    run_line(100);
    chk("box_py0", 32'(cap[1]), 32'h0000FF);
    run_line(100);
    chk("box_px0", 32'(cap[0]), 32'h0000FF);
    chk("box_px1", 32'(cap[1]), 32'hFFFFFF);
    chk("box_px64", 32'(cap[64]), 32'hFFFFFF);
    chk("box_px65", 32'(cap[65]), 32'h0000FF);

    // bounce at 640x480 and frame-counter wrap
    DRST = 1'b1;
    tick();
    DRST = 1'b0;
    for (int n = 1; n <= 577; n++) begin
      frame();
      if (n == 255) chk("frm_255", 32'(pif.FRMCNT), 32'd255);
      if (n == 256) chk("frm_wrap", 32'(pif.FRMCNT), 32'd0);
      if (n == 416) begin
        chk("by_416", 32'(dut.by), 32'd416);
        chk("diry_416", 32'(dut.diry), 32'd0);
      end
      if (n == 417) begin
        chk("by_417", 32'(dut.by), 32'd415);
        chk("diry_417", 32'(dut.diry), 32'd1);
      end
      if (n == 576) begin
        chk("bx_576", 32'(dut.bx), 32'd576);
        chk("dirx_576", 32'(dut.dirx), 32'd0);
      end
      if (n == 577) begin
        chk("bx_577", 32'(dut.bx), 32'd575);
        chk("dirx_577", 32'(dut.dirx), 32'd1);
      end
    end

    // clamp when resolution shrinks under the box
    DRST = 1'b1;
    tick();
    DRST = 1'b0;
    pif.RESOL = 2'd2;
    for (int n = 0; n < 800; n++) frame();
    chk("bx_800", 32'(dut.bx), 32'd800);
    chk("by_608", 32'(dut.by), 32'd608);
    pif.RESOL = 2'd0;
    frame();
    chk("clamp_bx", 32'(dut.bx), 32'd576);
    chk("clamp_dirx", 32'(dut.dirx), 32'd1);
    chk("clamp_by", 32'(dut.by), 32'd416);
    chk("clamp_diry", 32'(dut.diry), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
